// File: rtl/oam_dma_pkg.sv
// ---------------------------------------------------------------------------
// oam_dma_pkg
//   Shared NES bus constants and sprite-DMA state encoding. The address
//   constants are also used by the PPU register decoder and the CPU bus
//   decoder, so they live here rather than inside the DMA block.
// ---------------------------------------------------------------------------
package oam_dma_pkg;

    // CPU bus addresses
    localparam logic [15:0] NES_OAMDMA_ADDR  = 16'h4014;  // sprite DMA page register
    localparam logic [15:0] NES_OAMDATA_ADDR = 16'h2004;  // PPU OAMDATA (register select 4)

    // DMA state encoding
    localparam logic [2:0] DMA_IDLE  = 3'd0;
    localparam logic [2:0] DMA_HALT  = 3'd1;
    localparam logic [2:0] DMA_ALIGN = 3'd2;
    localparam logic [2:0] DMA_READ  = 3'd3;
    localparam logic [2:0] DMA_WRITE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = DMA_IDLE,
        S_HALT  = DMA_HALT,
        S_ALIGN = DMA_ALIGN,
        S_READ  = DMA_READ,
        S_WRITE = DMA_WRITE
    } dma_state_e;

endpackage : oam_dma_pkg

// File: rtl/oam_dma.sv
// ---------------------------------------------------------------------------
// oam_dma
//   Sprite DMA engine behind CPU register $4014. A CPU write of page P halts
//   the CPU, then the block owns the bus and copies $P00..$PFF into PPU OAM
//   through OAMDATA, one read/write pair per byte, and finally releases the
//   bus and lets the CPU run again.
//
//   All state changes on the falling edge of i_clk, the same edge on which
//   the PPU latches register writes. Outputs are decoded combinationally
//   from registered state and hold for the whole CPU cycle.
//
// Ports
//   i_clk          CPU cycle clock
//   i_reset_n      synchronous active-low reset
//   i_cpu_address  snooped CPU address bus
//   i_cpu_rw       snooped CPU read/~write (1 = read)
//   i_cpu_data     snooped CPU write data (supplies the source page)
//   o_cpu_rdy      0 halts the CPU
//   o_bus_master   1 when the DMA drives o_address/o_rw/o_data
//   o_address      DMA bus address
//   o_rw           DMA read/~write
//   o_data         DMA write data
//   i_data         bus read data during DMA reads
//   o_busy         1 from the first halt cycle through the last write
// ---------------------------------------------------------------------------
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter logic [15:0] TRIGGER_ADDR = NES_OAMDMA_ADDR,
    parameter logic [15:0] OAMDATA_ADDR = NES_OAMDATA_ADDR
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [15:0] i_cpu_address,
    input  logic        i_cpu_rw,
    input  logic [7:0]  i_cpu_data,
    output logic        o_cpu_rdy,
    output logic        o_bus_master,
    output logic [15:0] o_address,
    output logic        o_rw,
    output logic [7:0]  o_data,
    input  logic [7:0]  i_data,
    output logic        o_busy
);

    dma_state_e state_q, state_d;
    logic [7:0] page_q,  page_d;
    logic [7:0] index_q, index_d;
    logic [7:0] data_q,  data_d;
    logic       put_q,   put_d;     // 1 = current cycle is a put (write) cycle
    logic       trigger;

    // Next-state and output decode
    always_comb begin
        state_d      = state_q;
        page_d       = page_q;
        index_d      = index_q;
        data_d       = data_q;
        put_d        = ~put_q;

        o_cpu_rdy    = 1'b0;
        o_bus_master = 1'b0;
        o_busy       = 1'b1;
        o_address    = 16'h0000;
        o_rw         = 1'b1;
        o_data       = 8'h00;

        // o_bus_master is low whenever this term matters (only IDLE acts on
        // it); keeping it in the equation documents why DMA traffic can
        // never retrigger a transfer.
        trigger = (i_cpu_address == TRIGGER_ADDR) && !i_cpu_rw && !o_bus_master;

        unique case (state_q)
            S_IDLE: begin
                o_cpu_rdy = 1'b1;
                o_busy    = 1'b0;
                if (trigger) begin
                    page_d  = i_cpu_data;
                    index_d = 8'h00;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                // Reads must fall on get cycles; insert one idle cycle
                // when the cycle after HALT would be a put cycle.
                state_d = put_q ? S_READ : S_ALIGN;
            end
            S_ALIGN: begin
                state_d = S_READ;
            end
            S_READ: begin
                o_bus_master = 1'b1;
                o_rw         = 1'b1;
                o_address    = {page_q, index_q};
                data_d       = i_data;
                state_d      = S_WRITE;
            end
            S_WRITE: begin
                o_bus_master = 1'b1;
                o_rw         = 1'b0;
                o_address    = OAMDATA_ADDR;
                o_data       = data_q;
                if (index_q == 8'hFF) begin
                    state_d = S_IDLE;
                end else begin
                    index_d = index_q + 8'd1;   // wraps within the page only
                    state_d = S_READ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register, updated on the PPU's register-latch edge
    always_ff @(negedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            page_q  <= 8'h00;
            index_q <= 8'h00;
            data_q  <= 8'h00;
            put_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            index_q <= index_d;
            data_q  <= data_d;
            put_q   <= put_d;
        end
    end

endmodule : oam_dma

// File: tb/tb_oam_dma.sv
// ---------------------------------------------------------------------------
// tb_oam_dma
//   Directed bench for the sprite DMA engine. The DUT changes state on the
//   falling clock edge; the bench drives inputs just after that edge and
//   samples outputs on the rising edge, mid-cycle.
//   Memory model: byte at address A = A[7:0] ^ $5A ^ A[15:8] ^ $02, so page
//   $02 holds i^$5A.
// ---------------------------------------------------------------------------
module tb_oam_dma;

    logic        i_clk;
    logic        i_reset_n;
    logic [15:0] i_cpu_address;
    logic        i_cpu_rw;
    logic [7:0]  i_cpu_data;
    logic        o_cpu_rdy;
    logic        o_bus_master;
    logic [15:0] o_address;
    logic        o_rw;
    logic [7:0]  o_data;
    logic [7:0]  i_data;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    oam_dma dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_cpu_address (i_cpu_address),
        .i_cpu_rw      (i_cpu_rw),
        .i_cpu_data    (i_cpu_data),
        .o_cpu_rdy     (o_cpu_rdy),
        .o_bus_master  (o_bus_master),
        .o_address     (o_address),
        .o_rw          (o_rw),
        .o_data        (o_data),
        .i_data        (i_data),
        .o_busy        (o_busy)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'h02;
    endfunction

    assign i_data = (o_bus_master && o_rw) ? mem_byte(o_address) : 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        i_cpu_address = 16'h0000;
        i_cpu_rw      = 1'b1;
        i_cpu_data    = 8'h00;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rdy"},  {31'd0, o_cpu_rdy},    32'd1);
        check({tag, " bm"},   {31'd0, o_bus_master}, 32'd0);
        check({tag, " busy"}, {31'd0, o_busy},       32'd0);
        check({tag, " addr"}, {16'd0, o_address},    32'h0000);
        check({tag, " rw"},   {31'd0, o_rw},         32'd1);
        check({tag, " data"}, {24'd0, o_data},       32'h00);
    endtask

    // Issues the $4014 write in the current cycle and follows the transfer
    // to the first cycle with rdy high. With noise set, the CPU side keeps
    // presenting a $4014 write while the DMA runs. Returns sampled at the
    // rising edge of the first idle cycle.
    task automatic do_transfer(input logic [7:0] p, input int exp_halt,
                               input bit noise, input string tag);
        int halted, reads, writes, idle_halt, bad_busy;
        logic [7:0] expd;
        halted = 0; reads = 0; writes = 0; idle_halt = 0; bad_busy = 0;
        i_cpu_address = 16'h4014;
        i_cpu_rw      = 1'b0;
        i_cpu_data    = p;
        @(negedge i_clk); #1;
        if (noise) begin
            i_cpu_address = 16'h4014;
            i_cpu_rw      = 1'b0;
            i_cpu_data    = 8'hC3;
        end else begin
            idle_bus();
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge i_clk);
            if (o_cpu_rdy) break;
            halted++;
            if (!o_busy) bad_busy++;
            if (!o_bus_master) begin
                idle_halt++;
            end else if (o_rw) begin
                check({tag, " rd addr"}, {16'd0, o_address}, {16'd0, p, reads[7:0]});
                reads++;
            end else begin
                expd = mem_byte({p, writes[7:0]});
                check({tag, " wr addr"}, {16'd0, o_address}, 32'h2004);
                check({tag, " wr data"}, {24'd0, o_data}, {24'd0, expd});
                writes++;
                if (writes == 256) idle_bus();
            end
            @(negedge i_clk); #1;
        end
        check({tag, " halted cycles"}, halted, exp_halt);
        check({tag, " read count"}, reads, 256);
        check({tag, " write count"}, writes, 256);
        check({tag, " halt+align cycles"}, idle_halt, exp_halt - 512);
        check({tag, " busy during halt"}, bad_busy, 0);
        check({tag, " rdy after"}, {31'd0, o_cpu_rdy}, 32'd1);
        check({tag, " busy after"}, {31'd0, o_busy}, 32'd0);
        check({tag, " bm after"}, {31'd0, o_bus_master}, 32'd0);
    endtask

    initial begin
        bit found;
        i_reset_n = 1'b0;
        idle_bus();
        repeat (3) @(negedge i_clk);
        #1;
        i_reset_n = 1'b1;
        @(posedge i_clk);
        check_reset_outputs("reset");

        // First cycle after reset is a get cycle: no ALIGN, 513 halted cycles
        do_transfer(8'h02, 513, 1'b0, "get-aligned");

        // One cycle later (put cycle): ALIGN inserted, 514 halted cycles;
        // CPU keeps presenting $4014 writes that must be ignored
        @(negedge i_clk); #1;
        do_transfer(8'h02, 514, 1'b1, "put-aligned");

        // Back-to-back trigger in the first cycle with rdy high, page $07
        do_transfer(8'h07, 513, 1'b0, "back-to-back p07");

        // Non-triggers: CPU read of $4014, CPU write to $4015
        @(negedge i_clk); #1;
        i_cpu_address = 16'h4014; i_cpu_rw = 1'b1; i_cpu_data = 8'h02;
        @(negedge i_clk); #1;
        i_cpu_address = 16'h4015; i_cpu_rw = 1'b0; i_cpu_data = 8'h02;
        @(posedge i_clk);
        check("read 4014 rdy",  {31'd0, o_cpu_rdy}, 32'd1);
        check("read 4014 busy", {31'd0, o_busy},    32'd0);
        @(negedge i_clk); #1;
        idle_bus();
        @(posedge i_clk);
        check("write 4015 rdy",  {31'd0, o_cpu_rdy}, 32'd1);
        check("write 4015 busy", {31'd0, o_busy},    32'd0);
        @(negedge i_clk); #1;
        @(posedge i_clk);
        check("idle rdy", {31'd0, o_cpu_rdy}, 32'd1);

        // Reset during the READ of index 100
        i_cpu_address = 16'h4014; i_cpu_rw = 1'b0; i_cpu_data = 8'h02;
        @(negedge i_clk); #1;
        idle_bus();
        found = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge i_clk);
            if (o_bus_master && o_rw && o_address == 16'h0264) begin
                found = 1'b1;
                break;
            end
            @(negedge i_clk); #1;
        end
        check("reached read index 100", {31'd0, found}, 32'd1);
        i_reset_n = 1'b0;
        @(negedge i_clk); #1;
        i_reset_n = 1'b1;
        @(posedge i_clk);
        check_reset_outputs("mid-transfer reset");

        // Fresh transfer restarts at index 0; post-reset cycle is a get cycle
        do_transfer(8'h02, 513, 1'b0, "after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_oam_dma
